// File: rtl/main_memory.sv
// main_memory: behavioural backing store placed behind the cache arbiter.
// It serves one line-wide read or write at a time over a four-phase
// mem_enable/mem_ack handshake with a fixed access latency.
//
// Parameters:
//   LATENCY    cycles from request acceptance to mem_ack rising (1..255)
//   DEPTH_LOG2 log2 of the number of stored lines
//   WIDTH      line width in bits (power of two, at least 16)
//   REG_SIZE   byte-address width
//
// Ports:
//   clk           single clock, posedge
//   reset         synchronous, active-high
//   mem_enable    request valid, held by the requester until mem_ack
//   mem_rw        1 = read, 0 = write, sampled at acceptance
//   mem_ack       operation complete, held until mem_enable is sampled low
//   mem_addr      byte address, sampled at acceptance
//   mem_data_in   write line, sampled at acceptance
//   mem_data_out  read line, holds the last read value
//
// Optional feature (macro MEM_BOUNDS_CHECK_EN): an access with any address
// bit set above the indexed range is out of range. Such a write is dropped
// and such a read returns zero. Without the macro, addresses wrap.
module main_memory #(
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned REG_SIZE   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_enable,
  input  logic                mem_rw,
  output logic                mem_ack,
  input  logic [REG_SIZE-1:0] mem_addr,
  input  logic [WIDTH-1:0]    mem_data_in,
  output logic [WIDTH-1:0]    mem_data_out
);

  localparam int unsigned OFF = $clog2(WIDTH / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_t;

  state_t                r_state;
  logic [7:0]            r_cnt;
  logic                  r_rw;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_ack;
  logic [WIDTH-1:0]      r_rdata;
  logic [WIDTH-1:0]      r_mem [2**DEPTH_LOG2];

  logic                  w_done;
  logic                  w_oob;
  logic                  w_do_write;
  logic                  w_unused;

`ifdef MEM_BOUNDS_CHECK_EN
  logic r_oob;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_oob <= 1'b0;
    end else if (r_state == S_IDLE && mem_enable) begin
      r_oob <= |mem_addr[REG_SIZE-1:OFF+DEPTH_LOG2];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_done && r_oob) begin
      $display("main_memory: warning: out-of-range %s at line index %0d dropped",
               r_rw ? "read" : "write", r_idx);
    end
  end

  assign w_oob    = r_oob;
  assign w_unused = ^mem_addr[OFF-1:0];
`else
  assign w_oob    = 1'b0;
  assign w_unused = ^{mem_addr[OFF-1:0], mem_addr[REG_SIZE-1:OFF+DEPTH_LOG2]};
`endif

  // The access completes on the edge where the BUSY countdown reaches zero.
  // A coincident reset discards the access, so it also blocks the array write.
  always_comb begin
    w_done     = 1'b0;
    w_do_write = 1'b0;
    if (r_state == S_BUSY && r_cnt == 8'd0) begin
      w_done     = 1'b1;
      w_do_write = !r_rw && !w_oob && !reset;
    end
  end

  // The array is not reset; it holds X until each line is written.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_rw    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_enable) begin
            r_rw    <= mem_rw;
            r_idx   <= mem_addr[OFF+DEPTH_LOG2-1:OFF];
            r_wdata <= mem_data_in;
            r_cnt   <= 8'(LATENCY - 1);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
            if (r_rw) begin
              r_rdata <= w_oob ? '0 : r_mem[r_idx];
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_ACK: begin
          if (!mem_enable) begin
            r_ack   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_ack      = r_ack;
  assign mem_data_out = r_rdata;

endmodule

// File: tb/tb_main_memory.sv
// Directed testbench for main_memory with default parameters
// (LATENCY 5, DEPTH_LOG2 12, WIDTH 128, REG_SIZE 32, line offset 4 bits).
module tb_main_memory;

  localparam int unsigned LAT = 5;

  logic         clk;
  logic         reset;
  logic         mem_enable;
  logic         mem_rw;
  logic         mem_ack;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data_in;
  logic [127:0] mem_data_out;

  int checks;
  int errors;

  main_memory #(
    .LATENCY    (LAT),
    .DEPTH_LOG2 (12),
    .WIDTH      (128),
    .REG_SIZE   (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_enable   (mem_enable),
    .mem_rw       (mem_rw),
    .mem_ack      (mem_ack),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full handshake: drive at negedge, accept at the next posedge, count edges
  // until ack, release enable, wait for the edge that samples it low.
  // Returns #1 after that edge.
  task automatic do_req(input logic rw, input logic [31:0] addr,
                        input logic [127:0] wd, output int lat,
                        output logic [127:0] rd, output bit to);
    @(negedge clk);
    mem_enable  = 1'b1;
    mem_rw      = rw;
    mem_addr    = addr;
    mem_data_in = wd;
    @(posedge clk);
    lat = 0;
    to  = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ack && lat < 50);
    if (!mem_ack) to = 1'b1;
    rd          = mem_data_out;
    mem_enable  = 1'b0;
    mem_data_in = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_ack !== 1'b0 || mem_data_out !== 128'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: ack=%b data=%h required ack=0 data=0",
                 i, mem_ack, mem_data_out);
      end
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [127:0] rd;
    bit to;
    logic [127:0] pat;
    pat = {16{8'hA5}};
    do_req(1'b0, 32'h40, pat, lat, rd, to);
    checks++;
    if (to || lat != LAT) begin
      errors++;
      $display("FAIL write_latency: got %0d (timeout %0d) required %0d", lat, to, LAT);
    end
    checks++;
    if (mem_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_release: got %b required 0", mem_ack);
    end
    checks++;
    if (rd !== 128'd0) begin
      errors++;
      $display("FAIL write_keeps_dout: got %h required 0", rd);
    end
    do_req(1'b1, 32'h40, '0, lat, rd, to);
    checks++;
    if (to || lat != LAT) begin
      errors++;
      $display("FAIL read_latency: got %0d (timeout %0d) required %0d", lat, to, LAT);
    end
    checks++;
    if (rd !== pat) begin
      errors++;
      $display("FAIL read_data: got %h required %h", rd, pat);
    end
    // Low offset bits are ignored: 0x4F addresses the same line as 0x40.
    do_req(1'b1, 32'h4F, '0, lat, rd, to);
    checks++;
    if (to || rd !== pat) begin
      errors++;
      $display("FAIL read_offset_ignored: got %h required %h", rd, pat);
    end
  endtask

  task automatic test_hold_enable();
    int lat;
    logic [127:0] rd;
    bit to;
    logic [127:0] pat;
    pat = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    do_req(1'b0, 32'h300, pat, lat, rd, to);
    @(negedge clk);
    mem_enable = 1'b1;
    mem_rw     = 1'b1;
    mem_addr   = 32'h300;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ack && lat < 50);
    checks++;
    if (lat != LAT || mem_data_out !== pat) begin
      errors++;
      $display("FAIL hold_read: lat %0d data %h required lat %0d data %h",
               lat, mem_data_out, LAT, pat);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_ack !== 1'b1) begin
        errors++;
        $display("FAIL hold_ack_high cycle %0d: got %b required 1", i, mem_ack);
      end
    end
    mem_enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_ack !== 1'b0) begin
      errors++;
      $display("FAIL hold_ack_fall: got %b required 0", mem_ack);
    end
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_ack !== 1'b0 || mem_data_out !== pat) begin
        errors++;
        $display("FAIL hold_no_second_access cycle %0d: ack %b data %h required ack 0 data %h",
                 i, mem_ack, mem_data_out, pat);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [127:0] rd;
    bit to;
    logic [127:0] oldv;
    logic [127:0] newv;
    bit seen;
    oldv = {8{16'h1234}};
    newv = {8{16'hFFFF}};
    do_req(1'b0, 32'h80, oldv, lat, rd, to);
    @(negedge clk);
    mem_enable  = 1'b1;
    mem_rw      = 1'b0;
    mem_addr    = 32'h80;
    mem_data_in = newv;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b1;
    mem_enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (mem_ack !== 1'b0 || mem_data_out !== 128'd0) begin
      errors++;
      $display("FAIL reset_mid_ack: ack %b data %h required ack 0 data 0", mem_ack, mem_data_out);
    end
    seen = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #1;
      if (mem_ack) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_ack: got ack 1 required 0");
    end
    do_req(1'b1, 32'h80, '0, lat, rd, to);
    checks++;
    if (to || rd !== oldv) begin
      errors++;
      $display("FAIL reset_mid_contents: got %h required %h", rd, oldv);
    end
  endtask

  task automatic test_drop_in_busy();
    int hi;
    @(negedge clk);
    mem_enable = 1'b1;
    mem_rw     = 1'b1;
    mem_addr   = 32'h40;
    @(posedge clk);
    @(negedge clk);
    mem_enable = 1'b0;
    hi = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      if (i > 1) @(posedge clk);
      else @(posedge clk);
      #1;
      if (mem_ack) hi++;
      if (i == LAT) begin
        checks++;
        if (mem_ack !== 1'b1) begin
          errors++;
          $display("FAIL drop_busy_ack_edge: got %b required 1", mem_ack);
        end
      end
    end
    checks++;
    if (hi != 1) begin
      errors++;
      $display("FAIL drop_busy_pulse_len: got %0d cycles required 1", hi);
    end
    checks++;
    if (mem_data_out !== {16{8'hA5}}) begin
      errors++;
      $display("FAIL drop_busy_data: got %h required %h", mem_data_out, {16{8'hA5}});
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [127:0] rd;
    bit to;
    logic [127:0] ones;
    ones = {32{4'h1}};
    do_req(1'b0, 32'h0, ones, lat, rd, to);
    do_req(1'b1, 32'h0001_0000, '0, lat, rd, to);
`ifdef MEM_BOUNDS_CHECK_EN
    checks++;
    if (to || rd !== 128'd0) begin
      errors++;
      $display("FAIL bounds_read: got %h required 0", rd);
    end
    do_req(1'b0, 32'h0001_0000, {16{8'hEE}}, lat, rd, to);
    do_req(1'b1, 32'h0, '0, lat, rd, to);
    checks++;
    if (to || rd !== ones) begin
      errors++;
      $display("FAIL bounds_index0: got %h required %h", rd, ones);
    end
`else
    checks++;
    if (to || rd !== ones) begin
      errors++;
      $display("FAIL wrap_read: got %h required %h", rd, ones);
    end
`endif
  endtask

  // Write, D-read, I-read issued back to back at minimum spacing, in the
  // order the arbiter would grant them.
  task automatic test_back_to_back();
    int lat;
    logic [127:0] rd;
    bit to;
    logic [127:0] dline;
    logic [127:0] iline;
    dline = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    iline = 128'h13000093_00000013_FFF00113_00100093;
    do_req(1'b0, 32'h200, iline, lat, rd, to);
    do_req(1'b0, 32'h100, dline, lat, rd, to);
    checks++;
    if (to || lat != LAT) begin
      errors++;
      $display("FAIL b2b_write_latency: got %0d required %0d", lat, LAT);
    end
    do_req(1'b1, 32'h104, '0, lat, rd, to);
    checks++;
    if (to || lat != LAT || rd !== dline) begin
      errors++;
      $display("FAIL b2b_dread: lat %0d data %h required lat %0d data %h", lat, rd, LAT, dline);
    end
    do_req(1'b1, 32'h208, '0, lat, rd, to);
    checks++;
    if (to || lat != LAT || rd !== iline) begin
      errors++;
      $display("FAIL b2b_iread: lat %0d data %h required lat %0d data %h", lat, rd, LAT, iline);
    end
    do_req(1'b0, 32'h300, '0, lat, rd, to);
    checks++;
    if (rd !== iline) begin
      errors++;
      $display("FAIL b2b_write_keeps_dout: got %h required %h", rd, iline);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    mem_enable  = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    test_reset();
    test_write_read();
    test_hold_enable();
    test_reset_mid_write();
    test_drop_in_busy();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_memory.md
# main_memory

- Behavioural main-memory model that sits directly downstream of the cache arbiter.
- Serves one cache-line-wide (`WIDTH`) read or write at a time over the `mem_enable`/`mem_rw`/`mem_ack` four-phase handshake, with a configurable access latency.
- Used in simulation as the backing store for both I-cache and D-cache misses and D-cache write-backs.

## Interface

Parameters:
- `LATENCY`, default 5: cycles from request acceptance to `mem_ack` rising; legal range 1..255.
- `DEPTH_LOG2`, default 12: log2 of the number of `WIDTH`-bit lines stored.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `mem_enable`  in  1  request valid; held high by the arbiter until it sees `mem_ack`.
- `mem_rw`  in  1  1 = read, 0 = write; sampled at acceptance.
- `mem_ack`  out  1  operation complete; held until `mem_enable` is sampled low.
- `mem_addr`  in  `REG_SIZE`  byte address; sampled at acceptance.
- `mem_data_in`  in  `WIDTH`  write line; sampled at acceptance.
- `mem_data_out`  out  `WIDTH`  read line; valid while `mem_ack` = 1 after a read.

## Operation

- Storage is an array of 2^`DEPTH_LOG2` lines, each `WIDTH` bits wide.
- Line offset is `OFF` = log2(`WIDTH`/8).
- Line index is `mem_addr[OFF+DEPTH_LOG2-1:OFF]`. The low `OFF` bits are ignored.
- FSM states: IDLE, BUSY, ACK.
  - IDLE: when `mem_enable`=1 is sampled, latch `mem_rw`, the index, the upper address bits and `mem_data_in`. Load the counter with `LATENCY`-1 and go to BUSY.
  - BUSY: ignore `mem_enable`. Decrement the counter each cycle. On the edge where the counter is 0, perform the access, set `mem_ack`=1 and go to ACK.
    - Read: `mem_data_out` <= array[index].
    - Write: array[index] <= latched data.
  - ACK: keep `mem_ack`=1 while `mem_enable`=1. On the first edge that samples `mem_enable`=0, clear `mem_ack` and go to IDLE.
- A new request is accepted only from IDLE. This means at least one idle cycle with `mem_ack`=0 between operations, which is the condition the arbiter needs to return to its null state.
- `mem_data_out` holds the last read value. Writes never change it.
- If `mem_enable` drops during BUSY, the operation still completes. `mem_ack` then pulses for exactly one cycle.

## Timing

- Reset values: `mem_ack`=0, `mem_data_out`=0, state IDLE, counter 0.
- Array contents are not cleared by reset. They are X until written.
- Request sampled at edge N: `mem_ack` and the read data are visible after edge N+`LATENCY`. A write is committed at the same edge.
- Minimum back-to-back spacing: acceptance at N, ack after N+L, enable sampled low at N+L+1, IDLE after N+L+1. The next acceptance is no earlier than edge N+L+2.
- Reset mid-operation: a pending BUSY access is discarded, so no array write happens. `mem_ack` is 0 after the reset edge.
- Reset and `mem_enable` high in the same cycle: reset wins and the request is not accepted.
- `LATENCY`=1: ack rises at the edge after acceptance.

## Configuration

- `MEM_BOUNDS_CHECK_EN` defined:
  - An access is out of range if any latched `mem_addr` bit at or above `OFF+DEPTH_LOG2` is 1.
  - Out-of-range write: discarded, array unchanged.
  - Out-of-range read: `mem_data_out` = 0.
  - Handshake and latency are unchanged. `$display` prints one warning line per out-of-range access.
- `MEM_BOUNDS_CHECK_EN` undefined: upper address bits are ignored and addresses wrap modulo 2^`DEPTH_LOG2` lines.

## Test plan

- Reset, then idle 5 cycles -> `mem_ack`=0 and `mem_data_out`=0 throughout.
- With `LATENCY`=5: write line 0xA5A5…A5 to addr 0x40; release enable after ack. Then read 0x40 -> each ack rises exactly 5 edges after acceptance, and the read returns 0xA5A5…A5.
- Hold `mem_enable`=1 for 3 extra cycles after ack -> ack stays high. Ack falls one edge after enable is sampled low, and no second access occurs.
- Assert reset 2 cycles into a write to 0x80 -> no ack. A subsequent read of 0x80 returns its previous contents.
- Write 0x1111… to index 0, then read address 2^(`OFF+DEPTH_LOG2`):
  - Without `MEM_BOUNDS_CHECK_EN`: returns 0x1111… (wrap).
  - With `MEM_BOUNDS_CHECK_EN`: returns 0 plus a warning, and index 0 is unchanged.
- Connect to the arbiter: simultaneous D-write, D-read and I-read requests -> serviced in write, D-read, I-read order, each with correct data and ack.
